// File: rtl/toe_cam_ctrl.sv
// -----------------------------------------------------------------------------
// toe_cam_ctrl
//
// Session-table controller that sits in front of the 4-entry TOE CAM.
//  - Arbitrates user lookups against insert/delete updates. Updates win.
//  - Issues CAM lookups. A 1-bit tag rides a shift register that matches the
//    CAM latency, so each response can be routed to the user or to the
//    update engine.
//  - Performs an update as read-modify-write: look up the key, then write
//    the entry through the CAM RAM port.
//  - Owns allocation. CAM storage has no reset, so every entry is written to
//    zero after reset, and occupancy is tracked in a local bitmap.
//
// Ports
//  Clk, Rst               clock, synchronous active-high reset
//  LkpReq*/LkpRsp*        user lookup request (valid/ready) and response pulse
//  UpdReq*/UpdRsp*        insert(Op=1)/delete(Op=0) request and completion pulse
//  UsedCnt                number of live entries
//  CamRam*                CAM write port (Op is tied to write)
//  CamLookupReq*/Resp*    CAM lookup port, 2-cycle request-to-response latency
// -----------------------------------------------------------------------------
module toe_cam_ctrl #(
  parameter int K     = 97,
  parameter int V     = 14,
  parameter int N     = 4,
  parameter int A     = 2,
  parameter int D     = 115,
  parameter int VALID = 113
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         LkpReqValid,
  output logic         LkpReqReady,
  input  logic [K-1:0] LkpReqKey,
  output logic         LkpRspValid,
  output logic         LkpRspHit,
  output logic [A-1:0] LkpRspAddr,
  output logic [V-1:0] LkpRspValue,
  input  logic         UpdReqValid,
  output logic         UpdReqReady,
  input  logic         UpdReqOp,
  input  logic [K-1:0] UpdReqKey,
  input  logic [V-1:0] UpdReqValue,
  output logic         UpdRspValid,
  output logic         UpdRspOk,
  output logic [A-1:0] UpdRspAddr,
  output logic [A:0]   UsedCnt,
  output logic         CamRamReq,
  output logic         CamRamOp,
  output logic [A-1:0] CamRamAddr,
  output logic [D-1:0] CamRamData,
  output logic         CamLookupReqValid,
  output logic [K-1:0] CamLookupReqKey,
  input  logic         CamLookupRespValid,
  input  logic         CamLookupRespHit,
  input  logic [A-1:0] CamLookupRespAddr,
  input  logic [V-1:0] CamLookupRespValue
);

  // [0] is the cycle the request is on the CAM port; [STAGES] lines up with
  // the CAM response.
  localparam int STAGES = 2;

  typedef enum logic [2:0] {INIT, IDLE, LKP, WAIT, WRITE} state_e;

  state_e          state_q, state_d;
  logic [A-1:0]    init_q, init_d;
  logic [N-1:0]    occ_q, occ_d;

  // Latched update request and the CAM result for its key.
  logic            op_q;
  logic [K-1:0]    key_q;
  logic [V-1:0]    val_q;
  logic            rhit_q;
  logic [A-1:0]    raddr_q;

  logic [STAGES:0] vld_pipe_q, tag_pipe_q;
  logic [K-1:0]    cam_key_q;

  logic            lkp_vld_q, lkp_hit_q;
  logic [A-1:0]    lkp_addr_q;
  logic [V-1:0]    lkp_val_q;

  logic            upd_acc, lkp_acc, rsp_upd, rsp_lkp;
  logic [A-1:0]    free_addr;
  logic            full;
  logic [D-1:0]    ins_word;

  assign CamRamOp          = 1'b1;
  assign CamLookupReqValid = vld_pipe_q[0];
  assign CamLookupReqKey   = cam_key_q;
  assign LkpRspValid       = lkp_vld_q;
  assign LkpRspHit         = lkp_hit_q;
  assign LkpRspAddr        = lkp_addr_q;
  assign LkpRspValue       = lkp_val_q;

  assign upd_acc = UpdReqValid & UpdReqReady;
  assign lkp_acc = LkpReqValid & LkpReqReady;
  // Route the CAM response by the tag that was issued with it.
  assign rsp_upd = vld_pipe_q[STAGES] &  tag_pipe_q[STAGES] & CamLookupRespValid;
  assign rsp_lkp = vld_pipe_q[STAGES] & ~tag_pipe_q[STAGES] & CamLookupRespValid;

  // Lowest-index free slot and occupancy count.
  always_comb begin
    free_addr = '0;
    full      = &occ_q;
    for (int i = N-1; i >= 0; i--) begin
      if (!occ_q[i]) free_addr = A'(i);
    end
    UsedCnt = '0;
    for (int i = 0; i < N; i++) begin
      UsedCnt = UsedCnt + (A+1)'(occ_q[i]);
    end
  end

  always_comb begin
    ins_word               = '0;
    ins_word[K-1:0]        = key_q;
    ins_word[K+V-1:K]      = val_q;
    ins_word[VALID]        = 1'b1;
  end

  // Next state and combinational outputs. Everything is held quiet while
  // Rst is high, so an aborted update never writes or reports completion.
  always_comb begin
    state_d     = state_q;
    init_d      = init_q;
    occ_d       = occ_q;
    LkpReqReady = 1'b0;
    UpdReqReady = 1'b0;
    UpdRspValid = 1'b0;
    UpdRspOk    = 1'b0;
    UpdRspAddr  = '0;
    CamRamReq   = 1'b0;
    CamRamAddr  = '0;
    CamRamData  = '0;
    if (!Rst) begin
      unique case (state_q)
        INIT: begin
          CamRamReq  = 1'b1;
          CamRamAddr = init_q;
          init_d     = init_q + 1'b1;
          if (init_q == A'(N-1)) state_d = IDLE;
        end
        IDLE: begin
          UpdReqReady = 1'b1;
          LkpReqReady = ~UpdReqValid;
          if (UpdReqValid) state_d = LKP;
        end
        LKP: begin
          state_d = WAIT;
        end
        WAIT: begin
          // Older user lookups may still be draining; only the tagged
          // response moves us on.
          if (rsp_upd) state_d = WRITE;
        end
        WRITE: begin
          UpdRspValid = 1'b1;
          state_d     = IDLE;
          if (op_q) begin
            if (rhit_q) begin
              CamRamReq  = 1'b1;
              CamRamAddr = raddr_q;
              CamRamData = ins_word;
              UpdRspOk   = 1'b1;
              UpdRspAddr = raddr_q;
            end else if (!full) begin
              CamRamReq  = 1'b1;
              CamRamAddr = free_addr;
              CamRamData = ins_word;
              UpdRspOk   = 1'b1;
              UpdRspAddr = free_addr;
              occ_d[free_addr] = 1'b1;
            end
          end else if (rhit_q) begin
            CamRamReq  = 1'b1;
            CamRamAddr = raddr_q;
            UpdRspOk   = 1'b1;
            UpdRspAddr = raddr_q;
            occ_d[raddr_q] = 1'b0;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= INIT;
      init_q     <= '0;
      occ_q      <= '0;
      op_q       <= 1'b0;
      key_q      <= '0;
      val_q      <= '0;
      rhit_q     <= 1'b0;
      raddr_q    <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      cam_key_q  <= '0;
      lkp_vld_q  <= 1'b0;
      lkp_hit_q  <= 1'b0;
      lkp_addr_q <= '0;
      lkp_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      occ_q      <= occ_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], upd_acc | lkp_acc};
      tag_pipe_q <= {tag_pipe_q[STAGES-1:0], upd_acc};
      if (upd_acc)      cam_key_q <= UpdReqKey;
      else if (lkp_acc) cam_key_q <= LkpReqKey;
      if (upd_acc) begin
        op_q  <= UpdReqOp;
        key_q <= UpdReqKey;
        val_q <= UpdReqValue;
      end
      if (rsp_upd) begin
        rhit_q  <= CamLookupRespHit;
        raddr_q <= CamLookupRespAddr;
      end
      lkp_vld_q  <= rsp_lkp;
      lkp_hit_q  <= rsp_lkp & CamLookupRespHit;
      lkp_addr_q <= (rsp_lkp & CamLookupRespHit) ? CamLookupRespAddr  : '0;
      lkp_val_q  <= (rsp_lkp & CamLookupRespHit) ? CamLookupRespValue : '0;
    end
  end

endmodule

// File: doc/toe_cam_ctrl.md
# toe_cam_ctrl

Session-table controller placed directly upstream of the 4-entry TOE CAM (K=97 key, V=14 value, D=115 data word). It arbitrates user lookups against insert/delete updates and issues CAM lookups. It performs read-modify-write updates by looking up the key first, then writing through the CAM RAM port. It also owns entry allocation: CAM registers have no reset, so the controller clears every entry after reset and tracks occupancy itself.

## Interface
Parameters:
- K, 97, key width
- V, 14, value width
- N, 4, CAM entries
- A, 2, address width
- D, 115, CAM data word width
- VALID, 113, valid-bit index in data word

Ports:
- Clk  in  1  single clock
- Rst  in  1  reset; synchronous, active-high
- LkpReqValid  in  1  user lookup request
- LkpReqReady  out  1  lookup accepted when Valid&Ready
- LkpReqKey  in  K  lookup key
- LkpRspValid  out  1  lookup response pulse, no backpressure
- LkpRspHit  out  1  key found
- LkpRspAddr  out  A  hit entry (0 on miss)
- LkpRspValue  out  V  hit value (0 on miss)
- UpdReqValid  in  1  update request
- UpdReqReady  out  1  update accepted when Valid&Ready
- UpdReqOp  in  1  1=insert, 0=delete
- UpdReqKey  in  K  update key
- UpdReqValue  in  V  insert value (ignored on delete)
- UpdRspValid  out  1  update completion pulse
- UpdRspOk  out  1  1=success
- UpdRspAddr  out  A  entry written
- UsedCnt  out  A+1  number of valid entries
- CamRamReq, CamRamOp  out  1,1  CAM RAM port; Op is always 1 (write only)
- CamRamAddr  out  A  CAM write address
- CamRamData  out  D  CAM write data
- CamLookupReqValid  out  1  CAM lookup request
- CamLookupReqKey  out  K  CAM lookup key
- CamLookupRespValid, CamLookupRespHit  in  1,1  CAM response
- CamLookupRespAddr  in  A  CAM hit address
- CamLookupRespValue  in  V  CAM hit value

## Operation
- Data word layout:
  - [K-1:0] key
  - [K+V-1:K] value
  - [VALID] 1 for live entries
  - all other bits 0
  - A cleared entry is an all-zero word.
- FSM states: INIT, IDLE, LKP, WAIT, WRITE.
- INIT:
  - Entered on reset.
  - Writes the all-zero word to addresses 0..N-1, one per cycle (N cycles), then goes to IDLE.
  - Both Ready outputs are 0 during INIT.
- Occupancy:
  - Bitmap Occ[N-1:0] is cleared on reset.
  - UsedCnt = popcount(Occ).
- IDLE arbitration:
  - UpdReqReady = 1 in IDLE.
  - LkpReqReady = IDLE & ~UpdReqValid, so updates have priority. Lookup starvation under continuous updates is accepted.
- User lookup:
  - Request is registered onto CamLookupReqValid/Key the next cycle, with tag bit 0.
  - The tag rides a 2-stage shift register aligned with CAM latency.
  - A CAM response with tag 0 is registered onto LkpRsp* one cycle later. Addr and Value are forced to 0 on miss.
  - Throughput: 1 lookup per cycle.
- Update sequence:
  - IDLE→LKP on accept; UpdReq fields are latched.
  - LKP (1 cycle): issue CAM lookup of the key, tag 1.
  - WAIT: hold until the tag-1 response arrives.
  - WRITE: perform the write, pulse UpdRspValid, then return to IDLE.
- Insert on hit: overwrite the hit address with {VALID=1, new value, key}. Ok=1. Occ is unchanged.
- Insert on miss, free entry exists: write to the lowest-index clear Occ bit and set that bit. Ok=1.
- Insert on miss, table full (Occ all ones): no write, Ok=0, Addr=0.
- Delete on hit: write the zero word to the hit address and clear its Occ bit. Ok=1.
- Delete on miss: no write, Ok=0, Addr=0.
- Reset mid-operation: abort the FSM, discard the tag pipeline, clear Occ, restart INIT. Rst asserted during INIT restarts INIT at address 0.

## Timing
- Reset values: all outputs 0 except CamRamOp=1. During INIT: CamRamReq=1, CamRamData=0, CamRamAddr counts 0..N-1.
- Lookup accepted in cycle t:
  - CamLookupReqValid in cycle t+1.
  - CAM response in cycle t+3.
  - LkpRspValid in cycle t+4.
- Update accepted in cycle t:
  - CAM lookup in cycle t+1.
  - CAM response in cycle t+3.
  - WRITE state and UpdRspValid in cycle t+4, with CamRamReq=1 if writing.
  - IDLE in cycle t+5.
- Lookups accepted before an update are answered correctly. Lookups accepted from cycle t+5 onward see the written entry.
- After reset deasserts in cycle r: INIT occupies cycles r..r+N-1, and Ready is first high in cycle r+N.

## Test plan
- Reset, then hold UpdReqValid=0 → four zero writes to addr 0..3. LkpReqReady rises at cycle 4. Lookup of key 5 → Hit=0, Value=0, UsedCnt=0.
- Insert key 0x1A value 0x123 → UpdRspOk=1, Addr=0, UsedCnt=1, CamRamData[113]=1. Then lookup 0x1A → Hit=1, Addr=0, Value=0x123, LkpRspValid exactly 4 cycles after accept.
- Insert keys 1,2,3,4 → addresses 0..3. Then insert key 9 → Ok=0, no CamRamReq, UsedCnt=4.
- Insert key 2 value 0x3FFF when key 2 is at addr 1 → overwrite at addr 1, UsedCnt unchanged. Delete key 2 → Ok=1, Addr=1, UsedCnt=3. Next insert of a new key → allocated addr 1.
- UpdReqValid and LkpReqValid both high in IDLE → update accepted, LkpReqReady=0 until cycle t+5. Back-to-back lookups issued before the update return in order.
- Assert Rst in the WAIT state → UpdRspValid never pulses, INIT rewrites all 4 entries, and a lookup of a previously inserted key misses.
